// File: rtl/sonar_pkg.sv
// Shared types and helpers for the sonar round-robin scheduler.
package sonar_pkg;

   // Scheduler control states.
   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_FIRE,
      S_WAIT,
      S_GAP
   } sched_state_t;

   // Default distance word width of an HC_SR04 channel.
   localparam int DIST_W_DEFAULT = 16;

   // All-ones distance reported for a timed-out measurement (sliced to DIST_W).
   localparam logic [63:0] DIST_TIMEOUT = '1;

   // Width of a channel index; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Width of a timer that must reach max(a, b) without wrapping.
   function automatic int timer_w(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/sonar_scheduler_if.sv
// Control, sensor and result signals of the sonar scheduler.
// The scheduler connects through the slave modport; the controller side
// (sensors plus result consumer) uses the master modport.
interface sonar_scheduler_if
   import sonar_pkg::*;
#(
   parameter int N_SENSORS = 4,
   parameter int DIST_W    = DIST_W_DEFAULT
);
   localparam int ID_W = id_w(N_SENSORS);

   logic                          enable;
   logic [N_SENSORS-1:0]          sensor_mask;
   logic [N_SENSORS-1:0]          done_in;
   logic [N_SENSORS*DIST_W-1:0]   dist_in;
   logic [N_SENSORS-1:0]          go;
   logic [N_SENSORS-1:0]          sensor_abort;
   logic                          res_valid;
   logic [ID_W-1:0]               res_id;
   logic [DIST_W-1:0]             res_dist;
   logic                          res_timeout;
   logic                          frame_done;
   logic                          busy;

   modport slave (
      input  enable, sensor_mask, done_in, dist_in,
      output go, sensor_abort, res_valid, res_id, res_dist, res_timeout,
             frame_done, busy
   );

   modport master (
      output enable, sensor_mask, done_in, dist_in,
      input  go, sensor_abort, res_valid, res_id, res_dist, res_timeout,
             frame_done, busy
   );

endinterface

// File: rtl/sonar_scheduler_rr_next.sv
// Combinational round-robin finder: first set mask bit strictly after ptr,
// wrapping around; ptr itself is returned only when it is the sole set bit.
module rr_next
   import sonar_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = id_w(N)
) (
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] nxt,
   output logic          found,
   output logic          wrapped
);

   // Scan the N positions after ptr in order and keep the first hit.
   always_comb begin
      int idx;
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      nxt     = ptr;
      found   = 1'b0;
      wrapped = 1'b0;
      idx     = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && mask[idx]) begin
            found = 1'b1;
            nxt   = IW'(idx);
         end
      end
      wrapped = found && (nxt <= ptr);
   end

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin scheduler firing one ultrasonic channel at a time, waiting for
// its completion (or timing it out), then holding a quiet gap before the next
// trigger so echoes from one channel never reach another.
module sonar_scheduler
   import sonar_pkg::*;
#(
   parameter int N_SENSORS      = 4,
   parameter int DIST_W         = DIST_W_DEFAULT,
   parameter int TIMEOUT_CYCLES = 2000,
   parameter int GAP_CYCLES     = 3000
) (
   input  logic             internal_clk,
   input  logic             rst,
   sonar_scheduler_if.slave bus
);

   localparam int ID_W  = id_w(N_SENSORS);
   localparam int TMR_W = timer_w(TIMEOUT_CYCLES, GAP_CYCLES);

   localparam logic [TMR_W-1:0]  TO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0]  GAP_LAST = TMR_W'(GAP_CYCLES - 1);
   localparam logic [DIST_W-1:0] DIST_TO  = DIST_TIMEOUT[DIST_W-1:0];

   sched_state_t         state_q, state_d;
   logic [ID_W-1:0]      ptr_q, ptr_d;
   logic [TMR_W-1:0]     timer_q, timer_d;

   logic [N_SENSORS-1:0] go_d;
   logic [N_SENSORS-1:0] abort_d, abort_q;
   logic                 frame_done_d;
   logic                 res_fire, res_to;

   logic                 res_valid_q, res_timeout_q;
   logic [ID_W-1:0]      res_id_q;
   logic [DIST_W-1:0]    res_dist_q;

   logic [ID_W-1:0]      rr_idx;
   logic                 rr_found, rr_wrapped;

   rr_next #(
      .N  (N_SENSORS),
      .IW (ID_W)
   ) u_rr_next (
      .mask    (bus.sensor_mask),
      .ptr     (ptr_q),
      .nxt     (rr_idx),
      .found   (rr_found),
      .wrapped (rr_wrapped)
   );

   // Next-state, timer and output decode for the scheduler FSM.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      timer_d      = timer_q;
      go_d         = '0;
      abort_d      = '0;
      frame_done_d = 1'b0;
      res_fire     = 1'b0;
      res_to       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.enable && |bus.sensor_mask) state_d = S_SELECT;
         end

         S_SELECT: begin
            if (rr_found) begin
               ptr_d        = rr_idx;
               frame_done_d = rr_wrapped;
               state_d      = S_FIRE;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_FIRE: begin
            go_d[ptr_q] = 1'b1;
            timer_d     = '0;
            state_d     = S_WAIT;
         end

         S_WAIT: begin
            timer_d = timer_q + 1'b1;
            // A real completion wins over a timeout landing on the same cycle.
            if (bus.done_in[ptr_q]) begin
               res_fire = 1'b1;
               timer_d  = '0;
               state_d  = S_GAP;
            end else if (timer_q == TO_LAST) begin
               res_fire       = 1'b1;
               res_to         = 1'b1;
               abort_d[ptr_q] = 1'b1;
               timer_d        = '0;
               state_d        = S_GAP;
            end
         end

         S_GAP: begin
            timer_d = timer_q + 1'b1;
            // enable is only consulted once the gap has fully elapsed.
            if (timer_q == GAP_LAST) begin
               timer_d = '0;
               state_d = bus.enable ? S_SELECT : S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State, pointer, timer and registered result/abort outputs.
   always_ff @(posedge internal_clk) begin
      // NOTE: reset is synchronous, and every register here is a plain flop, so all of them take a reset value.
      if (rst) begin
         state_q       <= S_IDLE;
         ptr_q         <= ID_W'(N_SENSORS - 1);
         timer_q       <= '0;
         abort_q       <= '0;
         res_valid_q   <= 1'b0;
         res_id_q      <= '0;
         res_dist_q    <= '0;
         res_timeout_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         timer_q     <= timer_d;
         abort_q     <= abort_d;
         res_valid_q <= res_fire;
         if (res_fire) begin
            res_id_q      <= ptr_q;
            res_dist_q    <= res_to ? DIST_TO : bus.dist_in[ptr_q*DIST_W +: DIST_W];
            res_timeout_q <= res_to;
         end
      end
   end

   assign bus.go           = go_d;
   assign bus.sensor_abort = abort_q;
   assign bus.frame_done   = frame_done_d;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_id       = res_id_q;
   assign bus.res_dist     = res_dist_q;
   assign bus.res_timeout  = res_timeout_q;
   assign bus.busy         = (state_q != S_IDLE);

endmodule
